// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch FSM, decoder and circular queue feeding the ROB
// Optional FETCH_BTFN_PRED_EN: backward-taken / forward-not-taken branch prediction.
package instr_fetch_queue_pkg;
    localparam int unsigned IFQ_WIDTH = 32;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    typedef struct packed {
        logic [IFQ_WIDTH-1:0] pc;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [IFQ_WIDTH-1:0] imm;
        logic                 is_br_instr;
        logic [IFQ_WIDTH-1:0] branch_pc;
        logic                 br_pred;
    } pci_t;

    function automatic pci_t pci_reset();
        pci_t p;
        p        = '0;
        p.opcode = op_imm;
        return p;
    endfunction

    function automatic pci_t decode(input logic [IFQ_WIDTH-1:0] word,
                                    input logic [IFQ_WIDTH-1:0] pc);
        pci_t                 p;
        logic [IFQ_WIDTH-1:0] imm_i;
        logic [IFQ_WIDTH-1:0] imm_s;
        logic [IFQ_WIDTH-1:0] imm_b;
        logic [IFQ_WIDTH-1:0] imm_u;
        logic [IFQ_WIDTH-1:0] imm_j;
        p        = '0;
        p.pc     = pc;
        p.opcode = word[6:0];
        p.funct3 = word[14:12];
        p.funct7 = word[31:25];
        p.rd     = word[11:7];
        p.rs1    = word[19:15];
        p.rs2    = word[24:20];
        imm_i = {{20{word[31]}}, word[31:20]};
        imm_s = {{20{word[31]}}, word[31:25], word[11:7]};
        imm_b = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
        imm_u = {word[31:12], 12'b0};
        imm_j = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
        case (p.opcode)
            op_imm, op_load, op_jalr: p.imm = imm_i;
            op_store:                 p.imm = imm_s;
            op_br:                    p.imm = imm_b;
            op_lui, op_auipc:         p.imm = imm_u;
            op_jal:                   p.imm = imm_j;
            default:                  p.imm = '0;
        endcase
        p.is_br_instr = (p.opcode == op_br);
        if (p.opcode == op_br || p.opcode == op_jal) begin
            p.branch_pc = pc + p.imm;
        end
`ifdef FETCH_BTFN_PRED_EN
        p.br_pred = p.is_br_instr && p.imm[IFQ_WIDTH-1];
`else
        p.br_pred = 1'b0;
`endif
        return p;
    endfunction
endpackage

module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned          width    = IFQ_WIDTH,
    parameter int unsigned          depth    = 8,
    parameter logic [IFQ_WIDTH-1:0] pc_reset = 32'h00000060
) (
    input  logic             clk,
    input  logic             rst,
    output logic [width-1:0] instr_mem_address,
    output logic             instr_mem_read,
    input  logic [width-1:0] instr_mem_rdata,
    input  logic             instr_mem_resp,
    input  logic             dequeue,
    input  logic             flush_valid,
    input  logic [width-1:0] flush_pc,
    output pci_t             pci,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   fetch_pc_q, fetch_pc_d;
    logic [width-1:0]   drain_addr_q, drain_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic               started_q;
    logic [width-1:0]   mem_word_q [depth];
    logic [width-1:0]   mem_pc_q   [depth];

    pci_t               resp_pci;
    logic [width-1:0]   next_pc;
    logic               accept;
    logic               bypass;
    logic               bypass_take;
    logic               do_enq;
    logic               do_deq;

    // started_q keeps the read request low until the first edge after reset release
    assign instr_mem_read    = started_q && (state_q != S_FULL);
    assign instr_mem_address = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
    assign empty             = (count_q == '0);

    assign resp_pci    = decode(instr_mem_rdata, fetch_pc_q);
    assign accept      = (state_q == S_FETCH) && started_q && instr_mem_resp;
    assign bypass      = empty && accept && !flush_valid;
    assign bypass_take = bypass && dequeue;
    assign do_enq      = accept && !flush_valid && !bypass_take;
    assign do_deq      = dequeue && !flush_valid && !empty;

    always_comb begin
        next_pc = resp_pci.pc + width'(4);
        if (resp_pci.opcode == op_jal || (resp_pci.is_br_instr && resp_pci.br_pred)) begin
            next_pc = resp_pci.branch_pc;
        end
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_valid) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (do_enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        if (flush_valid) begin
            fetch_pc_d = flush_pc;
            case (state_q)
                S_FETCH: begin
                    if (instr_mem_read && !instr_mem_resp) begin
                        state_d      = S_DRAIN;
                        drain_addr_d = fetch_pc_q;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: state_d = instr_mem_resp ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        fetch_pc_d = next_pc;
                        state_d    = (count_d == CNT_W'(depth)) ? S_FULL : S_FETCH;
                    end
                end
                S_FULL: begin
                    if (count_d < CNT_W'(depth)) begin
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (instr_mem_resp) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= width'(pc_reset);
            drain_addr_q <= width'(pc_reset);
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            started_q    <= 1'b1;
        end
    end

    // raw words are stored and decoded at the head, so the queue holds pc+word only
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_word_q[tail_q] <= instr_mem_rdata;
            mem_pc_q[tail_q]   <= fetch_pc_q;
        end
    end

    always_comb begin
        pci = pci_reset();
        if (!empty) begin
            pci = decode(mem_word_q[head_q], mem_pc_q[head_q]);
        end else if (bypass) begin
            pci = resp_pci;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_mem_address;
    logic        instr_mem_read;
    logic [31:0] instr_mem_rdata = '0;
    logic        instr_mem_resp = 1'b0;
    logic        dequeue = 1'b0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = '0;
    pci_t        pci;
    logic        empty;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk               (clk),
        .rst               (rst),
        .instr_mem_address (instr_mem_address),
        .instr_mem_read    (instr_mem_read),
        .instr_mem_rdata   (instr_mem_rdata),
        .instr_mem_resp    (instr_mem_resp),
        .dequeue           (dequeue),
        .flush_valid       (flush_valid),
        .flush_pc          (flush_pc),
        .pci               (pci),
        .empty             (empty)
    );

    typedef struct {
        logic [6:0]  opc;
        int          imm;
        logic [4:0]  rd;
        bit          has_rd;
        logic [31:0] word;
    } ins_t;

    typedef struct {
        logic [31:0] pc;
        ins_t        ins;
    } ent_t;

    ins_t        prog [logic [31:0]];
    ent_t        q [$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] m_pc = 32'h60;
    logic [31:0] drain_addr = 32'h60;
    bit          draining = 0;
    int          mem_wait = -1;
    int          lat_min = 0;
    int          lat_max = 0;
    pci_t        last_pci;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // instructions are built from chosen fields, so expected decode comes from those fields
    function automatic ins_t mk(input logic [6:0] opc, input int imm, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
        ins_t        r;
        logic [31:0] u;
        u        = imm;
        r.opc    = opc;
        r.imm    = imm;
        r.rd     = rd;
        r.has_rd = 1;
        case (opc)
            op_store: begin r.word = {u[11:5], rs2, rs1, f3, u[4:0], opc}; r.has_rd = 0; end
            op_br:    begin r.word = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], opc}; r.has_rd = 0; end
            op_lui, op_auipc: r.word = {u[31:12], rd, opc};
            op_jal:   r.word = {u[20], u[10:1], u[11], u[19:12], rd, opc};
            op_reg:   begin r.word = {7'h20, rs2, rs1, f3, rd, opc}; r.imm = 0; end
            default:  r.word = {u[11:0], rs1, f3, rd, opc};
        endcase
        return r;
    endfunction

    function automatic ins_t gen();
        logic [4:0] rd  = 5'($urandom);
        logic [4:0] rs1 = 5'($urandom);
        logic [4:0] rs2 = 5'($urandom);
        logic [2:0] f3  = 3'($urandom);
        int         i12 = int'($urandom_range(0, 4095)) - 2048;
        case ($urandom_range(0, 7))
            0: return mk(op_imm, i12, rd, rs1, rs2, f3);
            1: return mk(op_load, i12, rd, rs1, rs2, f3);
            2: return mk(op_store, i12, rd, rs1, rs2, f3);
            3: return mk(op_br, (int'($urandom_range(0, 32)) - 16) * 4, rd, rs1, rs2, f3);
            4: return mk(op_jal, (int'($urandom_range(0, 64)) - 32) * 4, rd, rs1, rs2, f3);
            5: return mk(op_jalr, i12, rd, rs1, rs2, f3);
            6: return mk(op_lui, int'($urandom & 32'hFFFF_F000), rd, rs1, rs2, f3);
            default: return mk(op_reg, 0, rd, rs1, rs2, f3);
        endcase
    endfunction

    function automatic ins_t fetch_ins(input logic [31:0] addr);
        if (!prog.exists(addr)) prog[addr] = gen();
        return prog[addr];
    endfunction

    function automatic bit pred(input ins_t i);
`ifdef FETCH_BTFN_PRED_EN
        return (i.opc == op_br) && (i.imm < 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] pc, input ins_t i);
        if (i.opc == op_jal) return pc + i.imm;
        if (i.opc == op_br && pred(i)) return pc + i.imm;
        return pc + 4;
    endfunction

    task automatic chk_pci(input string tag, input pci_t p, input logic [31:0] pc, input ins_t i);
        logic [31:0] bpc;
        bpc = (i.opc == op_br || i.opc == op_jal) ? pc + i.imm : 32'h0;
        check({tag, ".pc"}, p.pc, pc);
        check({tag, ".opcode"}, p.opcode, i.opc);
        check({tag, ".imm"}, p.imm, i.imm);
        check({tag, ".is_br"}, p.is_br_instr, i.opc == op_br);
        check({tag, ".branch_pc"}, p.branch_pc, bpc);
        check({tag, ".br_pred"}, p.br_pred, pred(i));
        if (i.has_rd) check({tag, ".rd"}, p.rd, i.rd);
    endtask

    // one clock cycle: entered and left 1 time unit after a rising edge
    task automatic cycle(input bit deq, input bit fl, input logic [31:0] fpc);
        logic        rd_now;
        logic [31:0] addr_now;
        bit          resp;
        bit          byp_take;
        ins_t        ri;
        ent_t        e;
        rd_now   = instr_mem_read;
        addr_now = instr_mem_address;
        check("read", rd_now, draining || (q.size() < DEPTH));
        if (rd_now) check("addr", addr_now, draining ? drain_addr : m_pc);
        check("empty", empty, q.size() == 0);
        resp = 0;
        if (rd_now) begin
            if (mem_wait < 0) mem_wait = $urandom_range(lat_min, lat_max);
            if (mem_wait == 0) begin
                resp     = 1;
                mem_wait = -1;
            end else begin
                mem_wait--;
            end
        end else begin
            mem_wait = -1;
        end
        if (resp) ri = fetch_ins(addr_now);
        instr_mem_resp  = resp;
        instr_mem_rdata = resp ? ri.word : $urandom;
        dequeue         = deq;
        flush_valid     = fl;
        flush_pc        = fpc;
        #2;
        last_pci = pci;
        if (q.size() > 0) begin
            chk_pci("head", pci, q[0].pc, q[0].ins);
        end else if (resp && !fl && !draining) begin
            chk_pci("bypass", pci, m_pc, ri);
        end else begin
            check("idle.opcode", pci.opcode, op_imm);
            check("idle.pc", pci.pc, 0);
        end
        if (fl) begin
            if (rd_now && !resp) begin
                if (!draining) drain_addr = m_pc;
                draining = 1;
            end else begin
                draining = 0;
            end
            q.delete();
            m_pc = fpc;
        end else if (draining) begin
            if (resp) draining = 0;
        end else begin
            byp_take = resp && deq && (q.size() == 0);
            if (deq && q.size() > 0) void'(q.pop_front());
            if (resp) begin
                if (!byp_take) begin
                    e.pc  = m_pc;
                    e.ins = ri;
                    q.push_back(e);
                end
                m_pc = nxt(m_pc, ri);
            end
        end
        @(posedge clk);
        #1;
        instr_mem_resp = 0;
        dequeue        = 0;
        flush_valid    = 0;
    endtask

    task automatic do_reset();
        rst            = 0;
        instr_mem_resp = 0;
        dequeue        = 0;
        flush_valid    = 0;
        q.delete();
        draining = 0;
        m_pc     = 32'h60;
        mem_wait = -1;
        #2;
        check("rst.read", instr_mem_read, 0);
        check("rst.addr", instr_mem_address, 32'h60);
        check("rst.empty", empty, 1);
        check("rst.opcode", pci.opcode, op_imm);
        check("rst.pc", pci.pc, 0);
        check("rst.imm", pci.imm, 0);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rel.read", instr_mem_read, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // fill to FULL with one-cycle memory, no dequeue
        lat_min = 0;
        lat_max = 0;
        for (int a = 0; a < 9; a++) prog[32'h60 + 32'(a * 4)] = mk(op_imm, a + 1, 5'(a + 1), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);
        check("full.read", instr_mem_read, 0);
        check("full.empty", empty, 0);
        check("full.head_pc", pci.pc, 32'h60);

        // single dequeue from FULL resumes fetch at 0x80
        cycle(1, 0, 0);
        check("deq.head_pc", pci.pc, 32'h64);
        check("deq.read", instr_mem_read, 1);
        check("deq.addr", instr_mem_address, 32'h80);
        cycle(0, 0, 0);
        check("refill.read", instr_mem_read, 0);

        // bypass consumed in the same cycle
        do_reset();
        prog[32'h60] = mk(op_imm, 5, 1, 0, 0, 0);
        cycle(1, 0, 0);
        check("byp.rd", last_pci.rd, 1);
        check("byp.imm", last_pci.imm, 5);
        check("byp.empty", empty, 1);

        // jal redirect
        do_reset();
        prog[32'h60] = mk(op_jal, 32'h20, 0, 0, 0, 0);
        cycle(0, 0, 0);
        check("jal.branch_pc", last_pci.branch_pc, 32'h80);
        check("jal.addr", instr_mem_address, 32'h80);

        // flush with a read outstanding drains the stale response
        do_reset();
        lat_min = 2;
        lat_max = 2;
        cycle(0, 1, 32'h200);
        check("drain.addr", instr_mem_address, 32'h60);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("flush.addr", instr_mem_address, 32'h200);
        check("flush.read", instr_mem_read, 1);
        check("flush.empty", empty, 1);

        // backward branch
        lat_min = 0;
        lat_max = 0;
        prog[32'h100] = mk(op_br, -8, 0, 1, 2, 0);
        cycle(0, 1, 32'h100);
        cycle(0, 0, 0);
`ifdef FETCH_BTFN_PRED_EN
        check("br.pred", last_pci.br_pred, 1);
        check("br.addr", instr_mem_address, 32'hF8);
`else
        check("br.pred", last_pci.br_pred, 0);
        check("br.addr", instr_mem_address, 32'h104);
`endif

        // randomized traffic
        lat_min = 0;
        lat_max = 2;
        for (int i = 0; i < 2000; i++) begin
            int dpct;
            dpct = (i < 700) ? 20 : 70;
            if (i == 1000) do_reset();
            cycle($urandom_range(0, 99) < dpct, $urandom_range(0, 99) < 4,
                  32'h100 + 32'($urandom_range(0, 127)) * 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Front-end fetch unit and instruction queue that sits directly upstream of the reorder buffer. It drives a single-outstanding read handshake to instruction memory and decodes each returned word into a `pci_t`. Decoded entries are buffered in a circular FIFO and presented to the ROB, which consumes them through `dequeue`. A ROB flush redirects fetch and discards everything buffered or in flight.

## Interface
- `width`, 32, address/data width
- `depth`, 8, FIFO entries (power of two)
- `pc_reset`, 32'h00000060, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `instr_mem_address`  out  width  fetch address, held stable while `instr_mem_read` high
- `instr_mem_read`  out  1  fetch request
- `instr_mem_rdata`  in  width  instruction word, valid with `instr_mem_resp`
- `instr_mem_resp`  in  1  one-cycle completion of the outstanding read
- `dequeue`  in  1  ROB consumes `pci` this cycle
- `flush_valid`  in  1  ROB redirect
- `flush_pc`  in  width  redirect target
- `pci`  out  pci_t  front entry, or bypassed decode when empty
- `empty`  out  1  FIFO holds zero entries

## Operation
- Decode fills pc, opcode, funct3, funct7, rd, rs1, rs2, and the sign-extended immediate.
- `is_br_instr` = (opcode == op_br).
- `branch_pc` = pc + B-immediate for op_br, pc + J-immediate for op_jal, 0 otherwise, truncated to `width`.
- Next-fetch PC after an accepted response:
  - op_jal: pc + J-imm, with `br_pred`=0.
  - op_br: pc+4 and `br_pred`=0 (see Configuration).
  - All others, including op_jalr: pc+4. The ROB corrects jalr by flush.
- FSM states:
  - FETCH: `instr_mem_read`=1. On `instr_mem_resp`, the word is decoded and enqueued, `fetch_pc` advances, and the FSM goes to FETCH if `count` after the update < `depth`, else FULL.
  - FULL: `instr_mem_read`=0. The FSM returns to FETCH the cycle after a dequeue makes `count` < `depth`.
  - DRAIN: `instr_mem_read`=1 at the stale address. The response is discarded and the FSM goes to FETCH at `fetch_pc`.
- `count` is in 0..`depth`. Enqueue and dequeue in the same cycle leave `count` unchanged; head and tail wrap modulo `depth`.
- Bypass: when `empty`=1 and `instr_mem_resp`=1, `pci` shows the decode of `instr_mem_rdata` combinationally. If `dequeue`=1 that cycle, the word is consumed and not written, and `count` stays 0.
- A `dequeue` while `empty`=1 with no response is ignored.
- Flush has priority over dequeue, enqueue and bypass:
  - `count` goes to 0, head and tail go to 0, and `fetch_pc` is set to `flush_pc`.
  - Read outstanding and no response that cycle: go to DRAIN.
  - Response that same cycle: discard it and go to FETCH.
  - In FULL: go to FETCH.
  - Bypass is suppressed during the flush cycle.
- Reset values:
  - `fetch_pc`=`pc_reset`, `count`=0, head=tail=0, state=FETCH.
  - `instr_mem_read`=0 while `rst`=0, then 1 from the first clock edge after release.
  - `instr_mem_address`=`pc_reset`, `empty`=1.
  - `pci`: all fields 0 except opcode=op_imm.
- Reset asserted mid-request abandons the request; memory must tolerate the dropped read.

## Timing
- Response at cycle N goes to FIFO write at edge N+1. If the FIFO was non-empty, `pci` reflects the entry at the earliest from N+1 at the head.
- A response into an empty FIFO is visible at cycle N (bypass).
- The next request address is presented at N+1; there is no idle cycle between back-to-back fetches when the memory responds in one cycle.
- Flush at cycle F: the first request to `flush_pc` is at F+1, or at the cycle after the drained response.
- `empty` and `pci` are registered-state outputs except for the bypass path.

## Configuration
- `FETCH_BTFN_PRED_EN` defined: op_br with a negative B-immediate sets `br_pred`=1 and next `fetch_pc`=`branch_pc`. Forward branches keep `br_pred`=0 and pc+4.
- Not defined: every branch gets `br_pred`=0 and falls through to pc+4.

## Test plan
- Reset, then one-cycle memory returning op_imm words with `dequeue` held 0: addresses 0x60, 0x64, … 0x7C, eight entries, FSM enters FULL, `instr_mem_read`=0, `empty`=0.
- From FULL, a single `dequeue`: `pci`.pc advances to 0x64, one cycle later read resumes at 0x80, and `count` returns to 8.
- Empty FIFO, response 32'h00500093 with `dequeue`=1 at the same time: `pci`.rd=1, imm=5 in that cycle, `count` remains 0, `empty` stays 1.
- op_jal at 0x60 with J-imm=+0x20: `branch_pc`=0x80, next request address 0x80.
- `flush_valid` with `flush_pc`=0x200 while a read is outstanding: DRAIN, stale response dropped, next address 0x200, `empty`=1.
- With `FETCH_BTFN_PRED_EN`, op_br at 0x100 with imm=-8: `br_pred`=1, next address 0xF8. Without the macro: `br_pred`=0, next address 0x104.
